// File: rtl/cache_arbiter.sv
// Two-port arbiter that lets an instruction cache and a data cache share one
// physical memory port, one line transaction at a time with round-robin priority.
module cache_arbiter #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // instruction cache side
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  // data cache side
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  // physical memory side
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  localparam int OFFSET = $clog2(LINE_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    ~ADDR_WIDTH'((64'd1 << OFFSET) - 64'd1);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  typedef struct packed {
    logic                  rd;
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LINE_WIDTH-1:0] wdata;
  } mem_req_t;

  state_t   state;
  logic     last_d;   // 1 when the most recent grant went to the data cache
  mem_req_t req_q;

  logic i_act, d_act, grant_i, grant_d;

  assign i_act   = i_pmem_read;
  assign d_act   = d_pmem_read | d_pmem_write;
  assign grant_i = i_act & (~d_act | last_d);
  assign grant_d = d_act & ~grant_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      last_d <= 1'b1;
      req_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i) begin
            state       <= SERVE_I;
            last_d      <= 1'b0;
            req_q.rd    <= 1'b1;
            req_q.wr    <= 1'b0;
            req_q.addr  <= i_pmem_address & ALIGN_MASK;
            req_q.wdata <= '0;
          end else if (grant_d) begin
            // a simultaneous read+write from the data cache is a write-back
            state       <= SERVE_D;
            last_d      <= 1'b1;
            req_q.rd    <= ~d_pmem_write;
            req_q.wr    <= d_pmem_write;
            req_q.addr  <= d_pmem_address & ALIGN_MASK;
            req_q.wdata <= d_pmem_wdata;
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            state    <= IDLE;
            req_q.rd <= 1'b0;
            req_q.wr <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pmem_read    = req_q.rd;
  assign pmem_write   = req_q.wr;
  assign pmem_address = req_q.addr;
  assign pmem_wdata   = req_q.wdata;

  assign i_pmem_resp  = (state == SERVE_I) & pmem_resp;
  assign d_pmem_resp  = (state == SERVE_D) & pmem_resp;
  assign i_pmem_rdata = i_pmem_resp ? pmem_rdata : '0;
  assign d_pmem_rdata = d_pmem_resp ? pmem_rdata : '0;

endmodule
